// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - IF-stage fetch controller: PC ownership, variable-latency imem requests,
// freeze skid buffer and branch redirect/flush handling.
module fetch_sequencer #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instruction,
  output logic              if_valid,
  output logic              flush
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              if_valid_q, if_valid_d;

  logic              load;
  logic [31:0]       load_instr;
  logic [ADDR_W-1:0] load_pc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_addr;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    if_valid_d  = if_valid_q;
    load        = 1'b0;
    load_instr  = '0;
    load_pc     = '0;
    target      = {branch_addr[ADDR_W-1:2], 2'b00};
    next_addr   = req_addr_q + STEP;

    case (state_q)
      S_INIT: begin
        req_addr_d = fetch_pc_q;
        state_d    = S_REQ;
      end
      S_REQ: begin
        if (branch_taken && mem_ack) begin
          fetch_pc_d = target;
          req_addr_d = target;
        end else if (branch_taken) begin
          // Request cannot be withdrawn; remember the target and drain it in S_DROP.
          fetch_pc_d = target;
          state_d    = S_DROP;
        end else if (mem_ack && !hazard) begin
          load       = 1'b1;
          load_instr = mem_rdata;
          load_pc    = next_addr;
          fetch_pc_d = next_addr;
          req_addr_d = next_addr;
        end else if (mem_ack) begin
          buf_instr_d = mem_rdata;
          buf_pc_d    = next_addr;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          fetch_pc_d = target;
          req_addr_d = target;
          state_d    = S_REQ;
        end else if (!hazard) begin
          load       = 1'b1;
          load_instr = buf_instr_q;
          load_pc    = buf_pc_q;
          fetch_pc_d = buf_pc_q;
          req_addr_d = buf_pc_q;
          state_d    = S_REQ;
        end
      end
      S_DROP: begin
        if (branch_taken) fetch_pc_d = target;
        if (mem_ack) begin
          req_addr_d = branch_taken ? target : fetch_pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Branch beats freeze; an unfrozen cycle without a load presents a bubble.
    if (branch_taken) begin
      if_valid_d = 1'b0;
    end else if (!hazard) begin
      if (load) begin
        pc_d       = load_pc;
        instr_d    = load_instr;
        if_valid_d = 1'b1;
      end else begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
      if_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign mem_req     = (state_q == S_REQ) || (state_q == S_DROP);
  assign mem_addr    = req_addr_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign if_valid    = if_valid_q;
  assign flush       = branch_taken & rst;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        if_valid;
  logic        flush;

  int tests = 0;
  int fails = 0;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .pc           (pc),
    .instruction  (instruction),
    .if_valid     (if_valid),
    .flush        (flush)
  );

  always #5 clk = ~clk;

  // Memory content is the address tagged with 0xDEAD in the upper half.
  assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; hazard = 1'b0; branch_taken = 1'b1; branch_addr = 32'h0; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_flush_gated", flush, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instruction, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);

    branch_taken = 1'b0; rst = 1'b1; mem_ack = 1'b1;
    tick();
    check("init_mem_req", mem_req, 1);
    check("init_mem_addr", mem_addr, 0);
    check("init_if_valid", if_valid, 0);
    tick();
    check("zw1_valid", if_valid, 1);
    check("zw1_pc", pc, 32'h4);
    check("zw1_instr", instruction, 32'hDEAD_0000);
    check("zw1_addr", mem_addr, 32'h4);
    tick();
    check("zw2_pc", pc, 32'h8);
    check("zw2_instr", instruction, 32'hDEAD_0004);
    check("zw2_addr", mem_addr, 32'h8);

    hazard = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hz_pc", pc, 32'h8);
      check("hz_instr", instruction, 32'hDEAD_0004);
      check("hz_valid", if_valid, 1);
      check("hz_mem_req", mem_req, 0);
    end
    hazard = 1'b0;
    tick();
    check("hzrel_pc", pc, 32'hC);
    check("hzrel_instr", instruction, 32'hDEAD_0008);
    check("hzrel_addr", mem_addr, 32'hC);
    check("hzrel_req", mem_req, 1);
    tick();
    check("hznext_pc", pc, 32'h10);
    check("hznext_instr", instruction, 32'hDEAD_000C);

    mem_ack = 1'b0;
    tick();
    check("wait_addr", mem_addr, 32'h10);
    check("wait_bubble", if_valid, 0);
    branch_taken = 1'b1; branch_addr = 32'h43;
    #1;
    check("br_flush", flush, 1);
    tick();
    branch_taken = 1'b0;
    #1;
    check("drop_flush_low", flush, 0);
    check("drop_addr1", mem_addr, 32'h10);
    check("drop_req1", mem_req, 1);
    check("drop_valid1", if_valid, 0);
    tick();
    check("drop_addr2", mem_addr, 32'h10);
    mem_ack = 1'b1;
    tick();
    check("drop_retarget", mem_addr, 32'h40);
    check("drop_discard", if_valid, 0);
    check("drop_pc_hold", pc, 32'h10);
    tick();
    check("tgt_valid", if_valid, 1);
    check("tgt_pc", pc, 32'h44);
    check("tgt_instr", instruction, 32'hDEAD_0040);

    branch_taken = 1'b1; branch_addr = 32'h20; hazard = 1'b1; mem_ack = 1'b1;
    tick();
    check("bah_valid", if_valid, 0);
    check("bah_addr", mem_addr, 32'h20);
    check("bah_req", mem_req, 1);
    branch_taken = 1'b0; hazard = 1'b0;
    tick();
    check("bah_next_pc", pc, 32'h24);
    check("bah_next_instr", instruction, 32'hDEAD_0020);

    mem_ack = 1'b0; branch_taken = 1'b1; branch_addr = 32'h80;
    tick();
    check("dd_addr1", mem_addr, 32'h24);
    check("dd_valid", if_valid, 0);
    branch_addr = 32'hC0;
    tick();
    check("dd_addr2", mem_addr, 32'h24);
    branch_taken = 1'b0; mem_ack = 1'b1;
    tick();
    check("dd_retarget", mem_addr, 32'hC0);
    tick();
    check("dd_pc", pc, 32'hC4);
    check("dd_instr", instruction, 32'hDEAD_00C0);
    check("dd_valid2", if_valid, 1);

    mem_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", if_valid, 0);
    check("arst_pc", pc, 0);
    check("arst_instr", instruction, 0);
    check("arst_req", mem_req, 0);
    check("arst_addr", mem_addr, 0);

    @(negedge clk);
    rst = 1'b1;
    tick();
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF; mem_ack = 1'b1;
    tick();
    check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    check("wrap_bvalid", if_valid, 0);
    branch_taken = 1'b0;
    tick();
    check("wrap_valid", if_valid, 1);
    check("wrap_pc", pc, 32'h0);
    check("wrap_instr", instruction, 32'h2152_FFFC);
    check("wrap_next", mem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
